// File: rtl/a2bus_initiator.sv
// -----------------------------------------------------------------------------
// a2bus_initiator
//
// Motherboard side of the Apple II slot bus. Generates the 7M and PHI1 timing,
// holds the bus in reset for RESET_CYCLES bus cycles after rst_n release, and
// runs one queued read or write per bus cycle from a 1-deep command holding
// register. Every bus-facing output comes straight from a flop.
//
// Ports
//   clk, rst_n          logic clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake (ready = holding register empty and
//                       bus out of reset)
//   cmd_addr/wr/data    command address, 1 = write, write data
//   rsp_valid/wr/data   one-clk completion pulse, command type, read data (or
//                       the written data for writes)
//   a2_7m, a2_phi1      bus clocks (PHI0 is the inverse of PHI1)
//   a2_reset_n          bus reset
//   a2_addr, a2_rw_n    address bus and R/W (1 = read)
//   a2_d_o, a2_d_oe     write data and its output enable
//   a2_d_i              data bus input, sampled at the end of a read cycle
//   cycle_start         one-clk strobe on the first clk of each bus cycle
// -----------------------------------------------------------------------------
module a2bus_initiator #(
    parameter int          CLOCK_SPEED_HZ    = 54_000_000,
    parameter int          HALF_7M           = 4,
    parameter bit          LONG_CYCLE_ENABLE = 1'b1,
    parameter int          RESET_CYCLES      = 16,
    parameter logic [15:0] IDLE_ADDR         = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_addr,
    input  logic        cmd_wr,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    output logic        rsp_wr,
    output logic [7:0]  rsp_data,
    output logic        a2_7m,
    output logic        a2_phi1,
    output logic        a2_reset_n,
    output logic [15:0] a2_addr,
    output logic        a2_rw_n,
    output logic [7:0]  a2_d_o,
    output logic        a2_d_oe,
    input  logic [7:0]  a2_d_i,
    output logic        cycle_start
);

    localparam logic [3:0] PRE_LAST        = 4'(HALF_7M - 1);
    localparam logic [7:0] RST_LAST        = 8'(RESET_CYCLES - 1);
    localparam logic [3:0] HALF_SHORT_LAST = 4'd13;
    localparam logic [3:0] HALF_LONG_LAST  = 4'd15;
    localparam logic [3:0] HALF_PHI1_LAST  = 4'd6;
    localparam logic [3:0] HALF_PHI0_FIRST = 4'd7;
    localparam logic [6:0] CYC_LONG        = 7'd64;

    // Bus reset must last at least 1 us of real time.
    localparam longint RESET_CLKS = 64'(RESET_CYCLES) * 64'd14 * 64'(HALF_7M);

    if (HALF_7M < 2 || HALF_7M > 15) begin : g_bad_half_7m
        $error("a2bus_initiator: HALF_7M must be in 2..15");
    end
    if (RESET_CYCLES < 1 || RESET_CYCLES > 255) begin : g_bad_reset_cycles
        $error("a2bus_initiator: RESET_CYCLES must be in 1..255");
    end
    if (RESET_CLKS * 64'd1_000_000 < 64'(CLOCK_SPEED_HZ)) begin : g_short_reset
        $error("a2bus_initiator: bus reset shorter than 1 us");
    end

    logic [3:0]  pre_cnt_q,     pre_cnt_d;
    logic [3:0]  half_cnt_q,    half_cnt_d;
    logic [6:0]  cyc_cnt_q,     cyc_cnt_d;
    logic [7:0]  rst_cnt_q,     rst_cnt_d;
    logic        a2_7m_q,       a2_7m_d;
    logic        a2_phi1_q,     a2_phi1_d;
    logic        a2_reset_n_q,  a2_reset_n_d;
    logic [15:0] a2_addr_q,     a2_addr_d;
    logic        a2_rw_n_q,     a2_rw_n_d;
    logic [7:0]  a2_d_o_q,      a2_d_o_d;
    logic        a2_d_oe_q,     a2_d_oe_d;
    logic        active_q,      active_d;
    logic        pending_q,     pending_d;
    logic [15:0] hold_addr_q,   hold_addr_d;
    logic        hold_wr_q,     hold_wr_d;
    logic [7:0]  hold_data_q,   hold_data_d;
    logic        cmd_ready_q,   cmd_ready_d;
    logic        rsp_valid_q,   rsp_valid_d;
    logic        rsp_wr_q,      rsp_wr_d;
    logic [7:0]  rsp_data_q,    rsp_data_d;
    logic        cycle_start_q, cycle_start_d;

    logic        tick_s;
    logic        long_cycle_s;
    logic [3:0]  half_last_s;
    logic        cyc_end_s;
    logic        handoff_s;
    logic        accept_s;

    assign tick_s       = (pre_cnt_q == PRE_LAST);
    assign long_cycle_s = LONG_CYCLE_ENABLE && (cyc_cnt_q == CYC_LONG);
    assign half_last_s  = long_cycle_s ? HALF_LONG_LAST : HALF_SHORT_LAST;
    // The tick leaving the last half-period ends one cycle and starts the next.
    assign cyc_end_s    = tick_s && (half_cnt_q == half_last_s);
    // A held command only goes out once the bus was already out of reset.
    assign handoff_s    = cyc_end_s && a2_reset_n_q && pending_q;
    assign accept_s     = cmd_valid && cmd_ready_q;

    // State registers, asynchronous reset to the idle/bus-reset state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q     <= 4'd0;
            half_cnt_q    <= 4'd0;
            cyc_cnt_q     <= 7'd0;
            rst_cnt_q     <= 8'd0;
            a2_7m_q       <= 1'b0;
            a2_phi1_q     <= 1'b1;
            a2_reset_n_q  <= 1'b0;
            a2_addr_q     <= IDLE_ADDR;
            a2_rw_n_q     <= 1'b1;
            a2_d_o_q      <= 8'd0;
            a2_d_oe_q     <= 1'b0;
            active_q      <= 1'b0;
            pending_q     <= 1'b0;
            hold_addr_q   <= 16'd0;
            hold_wr_q     <= 1'b0;
            hold_data_q   <= 8'd0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_wr_q      <= 1'b0;
            rsp_data_q    <= 8'd0;
            cycle_start_q <= 1'b0;
        end else begin
            pre_cnt_q     <= pre_cnt_d;
            half_cnt_q    <= half_cnt_d;
            cyc_cnt_q     <= cyc_cnt_d;
            rst_cnt_q     <= rst_cnt_d;
            a2_7m_q       <= a2_7m_d;
            a2_phi1_q     <= a2_phi1_d;
            a2_reset_n_q  <= a2_reset_n_d;
            a2_addr_q     <= a2_addr_d;
            a2_rw_n_q     <= a2_rw_n_d;
            a2_d_o_q      <= a2_d_o_d;
            a2_d_oe_q     <= a2_d_oe_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            hold_addr_q   <= hold_addr_d;
            hold_wr_q     <= hold_wr_d;
            hold_data_q   <= hold_data_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_wr_q      <= rsp_wr_d;
            rsp_data_q    <= rsp_data_d;
            cycle_start_q <= cycle_start_d;
        end
    end

    // Next-state logic: timing chain, cycle start/end, bus reset, handshake.
    always_comb begin
        pre_cnt_d     = pre_cnt_q;
        half_cnt_d    = half_cnt_q;
        cyc_cnt_d     = cyc_cnt_q;
        rst_cnt_d     = rst_cnt_q;
        a2_7m_d       = a2_7m_q;
        a2_reset_n_d  = a2_reset_n_q;
        a2_addr_d     = a2_addr_q;
        a2_rw_n_d     = a2_rw_n_q;
        a2_d_o_d      = a2_d_o_q;
        a2_d_oe_d     = a2_d_oe_q;
        active_d      = active_q;
        pending_d     = pending_q;
        hold_addr_d   = hold_addr_q;
        hold_wr_d     = hold_wr_q;
        hold_data_d   = hold_data_q;
        rsp_valid_d   = 1'b0;
        rsp_wr_d      = rsp_wr_q;
        rsp_data_d    = rsp_data_q;
        cycle_start_d = 1'b0;

        if (tick_s) begin
            pre_cnt_d  = 4'd0;
            a2_7m_d    = ~a2_7m_q;
            half_cnt_d = cyc_end_s ? 4'd0 : (half_cnt_q + 4'd1);
        end else begin
            pre_cnt_d  = pre_cnt_q + 4'd1;
        end

        if (cyc_end_s) begin
            cycle_start_d = 1'b1;
            cyc_cnt_d     = (cyc_cnt_q == CYC_LONG) ? 7'd0 : (cyc_cnt_q + 7'd1);
            a2_d_oe_d     = 1'b0;

            if (!a2_reset_n_q) begin
                rst_cnt_d    = rst_cnt_q + 8'd1;
                a2_reset_n_d = (rst_cnt_q == RST_LAST);
            end else begin
                rst_cnt_d    = rst_cnt_q;
            end

            // Completion of the cycle that is ending now.
            if (active_q) begin
                rsp_valid_d = 1'b1;
                rsp_wr_d    = ~a2_rw_n_q;
                rsp_data_d  = a2_rw_n_q ? a2_d_i : a2_d_o_q;
            end else begin
                rsp_valid_d = 1'b0;
            end

            if (handoff_s) begin
                a2_addr_d = hold_addr_q;
                a2_rw_n_d = ~hold_wr_q;
                a2_d_o_d  = hold_data_q;
                active_d  = 1'b1;
                pending_d = 1'b0;
            end else begin
                a2_addr_d = IDLE_ADDR;
                a2_rw_n_d = 1'b1;
                active_d  = 1'b0;
            end
        end else if (tick_s && (half_cnt_q == HALF_PHI1_LAST) && active_q && !a2_rw_n_q) begin
            // Write data goes onto the bus for the PHI0 half only.
            a2_d_oe_d = 1'b1;
        end else begin
            a2_d_oe_d = a2_d_oe_q;
        end

        // cmd_ready is low while pending, so accept never collides with hand-off.
        if (accept_s) begin
            pending_d   = 1'b1;
            hold_addr_d = cmd_addr;
            hold_wr_d   = cmd_wr;
            hold_data_d = cmd_data;
        end else begin
            hold_addr_d = hold_addr_q;
        end
    end

    // Registered level outputs derived from the next state.
    always_comb begin
        a2_phi1_d   = (half_cnt_d < HALF_PHI0_FIRST);
        cmd_ready_d = ~pending_d & a2_reset_n_d;
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_wr      = rsp_wr_q;
    assign rsp_data    = rsp_data_q;
    assign a2_7m       = a2_7m_q;
    assign a2_phi1     = a2_phi1_q;
    assign a2_reset_n  = a2_reset_n_q;
    assign a2_addr     = a2_addr_q;
    assign a2_rw_n     = a2_rw_n_q;
    assign a2_d_o      = a2_d_o_q;
    assign a2_d_oe     = a2_d_oe_q;
    assign cycle_start = cycle_start_q;

endmodule

// File: doc/a2bus_initiator.md
Name: a2bus_initiator

Overview:
- Emulates the Apple II motherboard side of the slot bus: generates 7M and PHI1 timing, drives address, R/W and reset, performs queued read/write bus cycles and returns read data.
- Counterpart to the card-side bus responder (apple_bus/slotmaker/card stack). Used for the loopback self-test build and as the active bus model in card benches.
- Runs in the clk_logic domain; the bus outputs are registered.

Parameters:
- CLOCK_SPEED_HZ, 54_000_000, clk frequency; informational, used for the reset-length check only.
- HALF_7M, 4, clk cycles per 7M half-period (14M tick); legal range 2..15.
- LONG_CYCLE_ENABLE, 1, stretch every 65th bus cycle by 2 half-periods (Apple long cycle).
- RESET_CYCLES, 16, bus cycles a2_reset_n is held low after rst_n release; legal range 1..255.
- IDLE_ADDR, 16'hFFFF, address driven on cycles with no command (read, rw_n=1).

Ports:
- clk  in  1  logic clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command holding register empty and bus out of reset.
- cmd_addr  in  16  bus address.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_data  in  8  write data.
- rsp_valid  out  1  one-clk pulse at the end of each command cycle.
- rsp_wr  out  1  type of the completed command.
- rsp_data  out  8  sampled read data; for writes, the write data.
- a2_7m  out  1  7M clock.
- a2_phi1  out  1  PHI1; PHI0 is its inverse.
- a2_reset_n  out  1  bus reset.
- a2_addr  out  16  address bus.
- a2_rw_n  out  1  1 = read.
- a2_d_o  out  8  data driven on writes.
- a2_d_oe  out  1  data output enable.
- a2_d_i  in  8  data bus input, sampled on reads.
- cycle_start  out  1  one-clk strobe on the first clk of each bus cycle.

Behaviour:
- Reset values (async, rst_n low):
  - pre_cnt=0, half_cnt=0, cyc_cnt=0, rst_cnt=0.
  - a2_7m=0, a2_phi1=1, a2_reset_n=0, a2_addr=IDLE_ADDR, a2_rw_n=1, a2_d_o=0, a2_d_oe=0.
  - pending=0, cmd_ready=0, rsp_valid=0, rsp_wr=0, rsp_data=0, cycle_start=0.
- Prescaler: pre_cnt counts 0..HALF_7M-1. tick = (pre_cnt==HALF_7M-1). On each tick, a2_7m toggles and half_cnt advances.
- Cycle shape:
  - Short cycle: half_cnt 0..13, i.e. 14*HALF_7M clks.
  - Long cycle: half_cnt 0..15. A cycle is long when LONG_CYCLE_ENABLE and cyc_cnt==64.
  - a2_phi1 = 1 for half_cnt 0..6 and 0 for the rest, so PHI0 is 7 half-periods (9 on a long cycle).
  - cyc_cnt increments at each cycle start and wraps 64->0.
- Cycle start (tick with half_cnt at its last value → 0), registered:
  - cycle_start pulses.
  - If a2_reset_n==1 and pending: load a2_addr/a2_rw_n/a2_d_o from the holding register, clear pending, mark the cycle active.
  - Otherwise drive IDLE_ADDR with rw_n=1 and mark the cycle inactive.
  - a2_d_oe is forced to 0.
- Write data: a2_d_oe=1 from the tick that sets half_cnt=7 until the cycle end, on active write cycles only.
- Cycle end: on the tick leaving the last half_cnt, for an active cycle:
  - rsp_valid=1 on the next clk, for exactly one clk.
  - rsp_wr = type of the command.
  - rsp_data = a2_d_i sampled on that tick clk for reads, or a2_d_o for writes.
- Command handshake:
  - cmd_ready = !pending && a2_reset_n.
  - Accept on cmd_valid&&cmd_ready into the 1-deep holding register; pending=1 on the next clk.
  - Accept and hand-off in the same clk is legal only when pending is already 0; the holding register never overwrites.
  - A command accepted during a cycle executes on the next cycle start. Latency from accept to rsp_valid is at most 2 bus cycles + 1 clk.
- Bus reset:
  - rst_cnt increments at each cycle start while a2_reset_n==0.
  - a2_reset_n goes to 1 at the cycle start where rst_cnt==RESET_CYCLES-1.
  - That cycle is idle; commands are accepted from the next clk.
- Reset mid-operation: asserting rst_n aborts any cycle immediately. The pending command is discarded and no rsp_valid is generated.

Test Plan:
- Reset, HALF_7M=4: a2_7m period 8 clks; first 13 cycles short → cycle_start spacing 56 clks, a2_phi1 high 28 / low 28 clks; a2_reset_n rises at start of cycle 16; addr=FFFF, rw_n=1 throughout.
- Long cycle: count 65 cycle_start strobes → the cycle with cyc_cnt==64 is 64 clks with PHI0 low-phase 36 clks; with LONG_CYCLE_ENABLE=0 all cycles are 56 clks.
- Write C0B0←5A: addr=C0B0 and rw_n=0 on the next cycle start; a2_d_oe=1 with d_o=5A only during PHI0 (28 clks); rsp_valid pulse with rsp_wr=1, rsp_data=5A.
- Read C0B1 with a2_d_i=A5 at the end of PHI0 (and 00 earlier): rsp_data=A5, rsp_wr=0; a2_d_oe stays 0.
- Back-to-back: hold cmd_valid for 3 commands → cmd_ready drops after each accept; the commands execute on 3 consecutive cycles with no idle cycle between them; 3 rsp_valid pulses 56 clks apart.
- Cmd_valid during bus reset: cmd_ready=0 until a2_reset_n=1. Pulse rst_n mid-write: a2_d_oe=0, a2_reset_n=0, pending cleared, no rsp_valid.
